// File: rtl/uart_rx_ctrl_pkg.sv
// Shared types and constants for the UART receive controller.
package uart_rx_ctrl_pkg;

  localparam int unsigned BAUD_W            = 3;
  localparam int unsigned DEFAULT_DATA_BITS = 8;

  // Baud code loaded at reset
  localparam logic [BAUD_W-1:0] B_DEFAULT = 3'b100;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4
  } state_t;

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchronizer for the asynchronous serial line; resets to idle-high.
module uart_rx_sync (
  input  logic Clk,
  input  logic Rst,
  input  logic i_async,
  output logic o_sync
);

  logic r_meta;
  logic r_sync;

  // Double-register the line; preset high so reset never looks like a start edge
  always_ff @(posedge Clk) begin
    if (Rst) begin
      r_meta <= 1'b1;
      r_sync <= 1'b1;
    end else begin
      r_meta <= i_async;
      r_sync <= r_meta;
    end
  end

  assign o_sync = r_sync;

endmodule

// File: rtl/uart_rx_ctrl.sv
// UART receive controller: start-edge detect, mid-bit sampling on BaudTick,
// LSB-first shift, stop/parity checking. Define UART_RX_PARITY_EN to add a
// parity bit between the data bits and the stop bit.
module uart_rx_ctrl
  import uart_rx_ctrl_pkg::*;
#(
  parameter int unsigned DATA_BITS  = DEFAULT_DATA_BITS,
  parameter bit          PARITY_ODD = 1'b0
) (
  input  logic                 Clk,
  input  logic                 Rst,
  input  logic                 Rx,
  input  logic [BAUD_W-1:0]    Select,
  input  logic                 BaudTick,
  output logic                 BaudEn,
  output logic [BAUD_W-1:0]    BaudSel,
  output logic [DATA_BITS-1:0] RxData,
  output logic                 RxValid,
  output logic                 FrameErr,
  output logic                 ParityErr,
  output logic                 Busy
);

  localparam int unsigned CNT_W = $clog2(DATA_BITS);

`ifdef UART_RX_PARITY_EN
  localparam state_t S_AFTER_DATA = S_PARITY;
`else
  localparam state_t S_AFTER_DATA = S_STOP;
`endif

  logic                 w_rx_s;
  logic                 r_rx_prev;
  state_t               r_state,     w_state_nxt;
  logic [CNT_W-1:0]     r_bit_cnt,   w_bit_cnt_nxt;
  logic [DATA_BITS-1:0] r_shift,     w_shift_nxt;
  logic [DATA_BITS-1:0] r_rx_data,   w_rx_data_nxt;
  logic [BAUD_W-1:0]    r_baud_sel,  w_baud_sel_nxt;
  logic                 r_active;
  logic                 r_rx_valid,  w_rx_valid_nxt;
  logic                 r_frame_err, w_frame_err_nxt;
`ifdef UART_RX_PARITY_EN
  logic                 r_par_mis,   w_par_mis_nxt;
  logic                 r_par_err,   w_par_err_nxt;
`endif

  uart_rx_sync u_sync (
    .Clk     (Clk),
    .Rst     (Rst),
    .i_async (Rx),
    .o_sync  (w_rx_s)
  );

  // Next-state, datapath and pulse decode
  always_comb begin
    w_state_nxt     = r_state;
    w_bit_cnt_nxt   = r_bit_cnt;
    w_shift_nxt     = r_shift;
    w_rx_data_nxt   = r_rx_data;
    w_baud_sel_nxt  = r_baud_sel;
    w_rx_valid_nxt  = 1'b0;
    w_frame_err_nxt = 1'b0;
`ifdef UART_RX_PARITY_EN
    w_par_mis_nxt   = r_par_mis;
    w_par_err_nxt   = 1'b0;
`endif
    case (r_state)
      S_IDLE: begin
        w_baud_sel_nxt = Select;
        w_bit_cnt_nxt  = '0;
`ifdef UART_RX_PARITY_EN
        w_par_mis_nxt  = 1'b0;
`endif
        if (r_rx_prev && !w_rx_s) w_state_nxt = S_START;
      end
      S_START: begin
        // A high line at mid-start-bit is a glitch, not a frame
        if (BaudTick) begin
          w_bit_cnt_nxt = '0;
          w_state_nxt   = w_rx_s ? S_IDLE : S_DATA;
        end
      end
      S_DATA: begin
        if (BaudTick) begin
          w_shift_nxt   = {w_rx_s, r_shift[DATA_BITS-1:1]};
          w_bit_cnt_nxt = r_bit_cnt + 1'b1;
          if (r_bit_cnt == CNT_W'(DATA_BITS - 1)) w_state_nxt = S_AFTER_DATA;
        end
      end
`ifdef UART_RX_PARITY_EN
      S_PARITY: begin
        if (BaudTick) begin
          w_par_mis_nxt = (^r_shift) ^ w_rx_s ^ PARITY_ODD;
          w_state_nxt   = S_STOP;
        end
      end
`endif
      S_STOP: begin
        if (BaudTick) begin
          w_rx_data_nxt = r_shift;
          w_state_nxt   = S_IDLE;
          if (w_rx_s) begin
            w_rx_valid_nxt = 1'b1;
`ifdef UART_RX_PARITY_EN
            w_par_err_nxt  = r_par_mis;
`endif
          end else begin
            w_frame_err_nxt = 1'b1;
          end
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // State and output registers; BaudEn/Busy follow the next state so the
  // generator sees enable drop in the first IDLE cycle
  always_ff @(posedge Clk) begin
    if (Rst) begin
      r_state     <= S_IDLE;
      r_rx_prev   <= 1'b1;
      r_bit_cnt   <= '0;
      r_shift     <= '0;
      r_rx_data   <= '0;
      r_baud_sel  <= B_DEFAULT;
      r_active    <= 1'b0;
      r_rx_valid  <= 1'b0;
      r_frame_err <= 1'b0;
`ifdef UART_RX_PARITY_EN
      r_par_mis   <= 1'b0;
      r_par_err   <= 1'b0;
`endif
    end else begin
      r_state     <= w_state_nxt;
      r_rx_prev   <= w_rx_s;
      r_bit_cnt   <= w_bit_cnt_nxt;
      r_shift     <= w_shift_nxt;
      r_rx_data   <= w_rx_data_nxt;
      r_baud_sel  <= w_baud_sel_nxt;
      r_active    <= (w_state_nxt != S_IDLE);
      r_rx_valid  <= w_rx_valid_nxt;
      r_frame_err <= w_frame_err_nxt;
`ifdef UART_RX_PARITY_EN
      r_par_mis   <= w_par_mis_nxt;
      r_par_err   <= w_par_err_nxt;
`endif
    end
  end

  assign BaudEn   = r_active;
  assign Busy     = r_active;
  assign BaudSel  = r_baud_sel;
  assign RxData   = r_rx_data;
  assign RxValid  = r_rx_valid;
  assign FrameErr = r_frame_err;

`ifdef UART_RX_PARITY_EN
  assign ParityErr = r_par_err;
`else
  // Parity sense has no function when parity is compiled out
  logic w_unused_parity_odd;
  assign w_unused_parity_odd = PARITY_ODD;
  assign ParityErr = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Self-checking bench for uart_rx_ctrl: bench-side baud generator, serial
// frame driver, expected-event queue and a per-cycle compare process.
module tb_uart_rx_ctrl;

  localparam int unsigned DB = 8;
`ifdef UART_RX_PARITY_EN
  localparam int unsigned PAR = 1;
`else
  localparam int unsigned PAR = 0;
`endif
  localparam bit P_ODD = 1'b0;

  logic          Clk      = 1'b0;
  logic          Rst      = 1'b1;
  logic          Rx       = 1'b1;
  logic [2:0]    Select   = 3'b111;
  logic          BaudTick = 1'b0;
  logic          BaudEn;
  logic [2:0]    BaudSel;
  logic [DB-1:0] RxData;
  logic          RxValid;
  logic          FrameErr;
  logic          ParityErr;
  logic          Busy;

  uart_rx_ctrl #(.DATA_BITS(DB), .PARITY_ODD(P_ODD)) dut (
    .Clk       (Clk),
    .Rst       (Rst),
    .Rx        (Rx),
    .Select    (Select),
    .BaudTick  (BaudTick),
    .BaudEn    (BaudEn),
    .BaudSel   (BaudSel),
    .RxData    (RxData),
    .RxValid   (RxValid),
    .FrameErr  (FrameErr),
    .ParityErr (ParityErr),
    .Busy      (Busy)
  );

  always #5 Clk = ~Clk;

  int          n_chk = 0;
  int          n_fail = 0;
  int unsigned cyc = 0;

  always @(posedge Clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at cycle %0d", nm, got, exp, cyc);
    end
  endtask

  // Bench baud generator: bit period per code, half-period preload while disabled
  function automatic int unsigned period(input logic [2:0] s);
    return 31 + 10 * int'(s);
  endfunction

  int unsigned gcnt  = 0;
  logic        stray = 1'b0;

  always @(posedge Clk) begin
    #2;
    if (!BaudEn) begin
      gcnt     = period(BaudSel) / 2;
      BaudTick = stray;
    end else if (gcnt == 0) begin
      BaudTick = 1'b1;
      gcnt     = period(BaudSel) - 1;
    end else begin
      BaudTick = 1'b0;
      gcnt     = gcnt - 1;
    end
  end

  // Expected frame outcomes
  typedef struct {
    logic [DB-1:0] data;
    logic          valid;
    logic          ferr;
    logic          perr;
    int unsigned   start;
    int unsigned   due;
  } ev_t;

  ev_t         q[$];
  ev_t         cur;
  int unsigned last_lat   = 0;
  logic [2:0]  last_flags = 3'b000;

  bit         rst_p  = 1'b1;
  bit         busy_p = 1'b0;
  logic [2:0] sel_p  = 3'b111;
  logic [2:0] bsel_p = 3'b100;

  // Per-cycle compare against the behavioural rules
  always @(negedge Clk) begin
    if (rst_p) begin
      chk("reset_outputs", {Busy, BaudEn, RxValid, FrameErr, ParityErr, BaudSel, RxData},
          {5'b00000, 3'b100, 8'h00});
    end else begin
      chk("baud_sel", BaudSel, busy_p ? bsel_p : sel_p);
      chk("baud_en_vs_busy", BaudEn, Busy);
      if (RxValid || FrameErr) begin
        if (q.size() == 0) begin
          chk("unexpected_pulse", {RxValid, FrameErr}, 2'b00);
        end else begin
          cur = q.pop_front();
          chk("pulse_flags", {RxValid, FrameErr, ParityErr}, {cur.valid, cur.ferr, cur.perr});
          chk("rx_data", RxData, cur.data);
          chk("pulse_cycle", cyc, cur.due);
          chk("idle_at_pulse", {Busy, BaudEn}, 2'b00);
          last_lat   = cyc - cur.start;
          last_flags = {RxValid, FrameErr, ParityErr};
        end
      end else begin
        chk("stray_parity_err", ParityErr, 1'b0);
      end
    end
    rst_p  = Rst;
    busy_p = Busy;
    sel_p  = Select;
    bsel_p = BaudSel;
  end

  task automatic step(input int unsigned n);
    repeat (n) begin
      @(posedge Clk);
      #1;
    end
  endtask

  task automatic idle_gap(input int unsigned n);
    Rx = 1'b1;
    for (int i = 0; i < int'(n); i++) begin
      stray = (i == 2) && ($urandom_range(0, 1) == 1);
      step(1);
    end
    stray = 1'b0;
  endtask

  // Drive one frame at the currently requested baud code and queue its outcome
  task automatic send_frame(input logic [DB-1:0] d, input logic stop_b, input logic par_b);
    int unsigned p;
    ev_t         e;
    p       = period(Select);
    e.data  = d;
    e.valid = stop_b;
    e.ferr  = !stop_b;
    e.perr  = (PAR != 0) && stop_b && ((^d) ^ par_b ^ P_ODD);
    e.start = cyc;
    e.due   = cyc + (1 + DB + PAR) * p + p / 2 + 4;
    q.push_back(e);
    Rx = 1'b0;
    step(p);
    for (int i = 0; i < int'(DB); i++) begin
      Rx = d[i];
      step(p);
    end
    if (PAR != 0) begin
      Rx = par_b;
      step(p);
    end
    Rx = stop_b;
    step(p);
    Rx = 1'b1;
    chk("frame_done", 32'(q.size()), 32'd0);
    q.delete();
  endtask

  initial begin
    int unsigned   c0;
    int unsigned   p;
    logic [DB-1:0] d;
    @(posedge Clk);
    #1;
    step(3);
    Rst = 1'b0;
    idle_gap(6);

    // Good 8N1 frame at the slowest code
    send_frame(8'hA5, 1'b1, ^8'hA5);
    chk("a5_data_literal", RxData, 8'hA5);
    chk("a5_flags_literal", last_flags, 3'b100);
    chk("a5_latency_literal", last_lat, (PAR != 0) ? 32'd1064 : 32'd963);

    // Short low pulse: START must reject it at the first tick
    idle_gap(6);
    p  = period(Select);
    c0 = cyc;
    Rx = 1'b0;
    step(20);
    Rx = 1'b1;
    step(c0 + p / 2 + 3 - cyc);
    chk("glitch_busy_before_tick", Busy, 1'b1);
    step(1);
    chk("glitch_idle_after_tick", {Busy, BaudEn}, 2'b00);

    // Stop bit sampled low
    idle_gap(6);
    send_frame(8'h3C, 1'b0, 1'b0);
    chk("3c_data_literal", RxData, 8'h3C);
    chk("3c_flags_literal", last_flags, 3'b010);

    // Parity mismatch then match (parity bits ignored when not compiled in)
    idle_gap(6);
    send_frame(8'h03, 1'b1, 1'b1);
    chk("par_bad_literal", last_flags, (PAR != 0) ? 3'b101 : 3'b100);
    idle_gap(6);
    send_frame(8'h03, 1'b1, 1'b0);
    chk("par_good_literal", last_flags, 3'b100);

    // Reset during data bit 4, then a clean frame
    idle_gap(6);
    p  = period(Select);
    d  = 8'h96;
    Rx = 1'b0;
    step(p);
    for (int i = 0; i < 4; i++) begin
      Rx = d[i];
      step(p);
    end
    Rx = d[4];
    step(p / 2);
    Rst = 1'b1;
    Rx  = 1'b1;
    step(1);
    chk("rst_mid_frame", {Busy, BaudEn, RxValid, FrameErr, ParityErr, BaudSel, RxData},
        {5'b00000, 3'b100, 8'h00});
    step(1);
    Rst = 1'b0;
    idle_gap(6);
    send_frame(8'h5A, 1'b1, ^8'h5A);
    chk("5a_data_literal", RxData, 8'h5A);

    // Select changes mid-frame; BaudSel holds until IDLE
    idle_gap(6);
    fork
      send_frame(8'hC3, 1'b1, ^8'hC3);
      begin
        step(300);
        Select = 3'b000;
        step(200);
        chk("sel_hold_mid_frame", BaudSel, 3'b111);
      end
    join
    chk("sel_after_idle", BaudSel, 3'b000);

    // Randomised frames across baud codes
    for (int k = 0; k < 12; k++) begin
      Select = 3'($urandom_range(0, 7));
      idle_gap(6 + $urandom_range(0, 5));
      d = DB'($urandom);
      send_frame(d, $urandom_range(0, 3) != 0, 1'($urandom));
    end

    idle_gap(10);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  // Watchdog against a hung run
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "timeout");
  end

endmodule
